// File: rtl/csa_accum_seq.sv
// csa_accum_seq: sequential multi-operand accumulator.
// Each accepted beat carries LANES unsigned operands. A carry-save tree folds
// them into a (sum, carry) register pair. After BEATS beats, one carry-propagate
// add resolves the pair into out_sum.
//
// Ports:
//   clk, rst   - clock; asynchronous active-high reset
//   clr        - synchronous abort (drops partial sum / pending result)
//   in_valid / in_ready / in_data  - beat input, lane j = in_data[j*SIZE_I +: SIZE_I]
//   out_valid / out_ready / out_sum - resolved result handshake
//   busy       - any state other than IDLE

// One 3:2 compressor level across the full word. The carry vector is returned
// already shifted into its weight, so callers can treat both outputs alike.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);
  logic [W-1:0] maj;
  assign s   = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
  assign cy  = maj << 1;  // top bit drops out: arithmetic is mod 2^W
endmodule

// Reduces N aligned operands to a carry-save pair with a chain of 3:2 levels.
// Purely combinational; ops[0]/ops[1] seed the chain.
module csa_tree_6to3 #(
  parameter int W = 8,
  parameter int N = 6
) (
  input  logic [N-1:0][W-1:0] ops,
  output logic [W-1:0]        sum,
  output logic [W-1:0]        carry
);
  logic [N-2:0][W-1:0] s_ch;
  logic [N-2:0][W-1:0] c_ch;

  assign s_ch[0] = ops[0];
  assign c_ch[0] = ops[1];

  for (genvar k = 0; k < N-2; k++) begin : g_lvl
    csa_3to2 #(.W(W)) u_csa (
      .a  (s_ch[k]),
      .b  (c_ch[k]),
      .c  (ops[k+2]),
      .s  (s_ch[k+1]),
      .cy (c_ch[k+1])
    );
  end

  assign sum   = s_ch[N-2];
  assign carry = c_ch[N-2];
endmodule

module csa_accum_seq #(
  parameter int SIZE_I = 32,
  parameter int LANES  = 4,
  parameter int BEATS  = 8,
  parameter int SIZE_O = SIZE_I + $clog2(LANES*BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*SIZE_I-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE_O-1:0]       out_sum,
  output logic                    busy
);
  localparam int N  = LANES + 2;
  localparam int CW = $clog2(BEATS+1);

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, OUT} state_t;

  state_t                  state_q, state_d;
  logic [SIZE_O-1:0]       sum_r, carry_r;
  logic [CW-1:0]           beat_cnt;
  logic                    accept, last_beat;
  logic [N-1:0][SIZE_O-1:0] ops;
  logic [SIZE_O-1:0]       tree_s, tree_c;

  // Feedback is forced to zero outside ACC so the first beat starts clean
  // even if a register were somehow left non-zero.
  always_comb begin
    ops    = '0;
    ops[0] = (state_q == ACC) ? sum_r   : '0;
    ops[1] = (state_q == ACC) ? carry_r : '0;
    for (int j = 0; j < LANES; j++)
      ops[j+2] = SIZE_O'(in_data[j*SIZE_I +: SIZE_I]);
  end

  csa_tree_6to3 #(.W(SIZE_O), .N(N)) u_tree (
    .ops   (ops),
    .sum   (tree_s),
    .carry (tree_c)
  );

  assign in_ready  = ((state_q == IDLE) || (state_q == ACC)) && !clr;
  assign accept    = in_valid && in_ready;
  // beat_cnt is 0 in IDLE, so this also covers BEATS==1 from IDLE.
  assign last_beat = (beat_cnt == CW'(BEATS-1));
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last_beat ? RESOLVE : ACC;
      ACC:     if (accept && last_beat) state_d = RESOLVE;
      RESOLVE: state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r     <= '0;
      carry_r   <= '0;
      beat_cnt  <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      // out_sum is deliberately held; only the pending valid is dropped.
      sum_r     <= '0;
      carry_r   <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        sum_r    <= tree_s;
        carry_r  <= tree_c;
        beat_cnt <= beat_cnt + CW'(1);
      end
      if (state_q == RESOLVE) begin
        out_sum   <= sum_r + carry_r;
        out_valid <= 1'b1;
        sum_r     <= '0;
        carry_r   <= '0;
        beat_cnt  <= '0;
      end
      if ((state_q == OUT) && out_ready)
        out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_csa_accum_seq.sv
// Bench for csa_accum_seq (SIZE_I=8, LANES=4, BEATS=8 -> SIZE_O=13).
// Stimulus pushes expected sums into a queue; a monitor pops on each output
// handshake. Inputs change 1 time unit after posedge; sampling is on negedge.
module tb_csa_accum_seq;
  localparam int SIZE_I = 8;
  localparam int LANES  = 4;
  localparam int BEATS  = 8;
  localparam int SIZE_O = SIZE_I + $clog2(LANES*BEATS);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    clr = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES*SIZE_I-1:0] in_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [SIZE_O-1:0]       out_sum;
  logic                    busy;

  csa_accum_seq #(.SIZE_I(SIZE_I), .LANES(LANES), .BEATS(BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_q[$];
  int pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a result is consumed when valid and ready meet.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(out_sum), -1);
      end else begin
        chk("out_sum", int'(out_sum), exp_q.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Present one beat and hold it until it is accepted (bounded).
  task automatic drive_beat(input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    // Reset state
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum",   int'(out_sum),   0);
    chk("rst_busy",      int'(busy),      0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    step();

    // 1: all 255, streaming, check latency and busy after handshake
    out_ready = 1'b1;
    exp_q.push_back(8160);
    for (int b = 0; b < BEATS; b++) drive_beat(32'hFFFF_FFFF);
    @(negedge clk);                       // RESOLVE
    chk("lat_resolve_valid", int'(out_valid), 0);
    chk("lat_resolve_busy",  int'(busy),      1);
    @(negedge clk);                       // OUT
    chk("lat_out_valid", int'(out_valid), 1);
    @(negedge clk);                       // after handshake
    chk("post_hs_busy",     int'(busy),      0);
    chk("post_hs_valid",    int'(out_valid), 0);
    chk("post_hs_in_ready", int'(in_ready),  1);
    chk("post_hs_sum_hold", int'(out_sum),   8160);
    step();

    // 2: lanes b*4+j with a bubble after every beat -> 496
    exp_q.push_back(496);
    for (int b = 0; b < BEATS; b++) begin
      base = b * 4;
      drive_beat({8'(base+3), 8'(base+2), 8'(base+1), 8'(base)});
      @(negedge clk);
      chk("bubble_beat_cnt", int'(dut.beat_cnt), b + 1);
      step();
    end
    repeat (3) step();

    // 3: out_ready low for 5 cycles, result must hold
    out_ready = 1'b0;
    exp_q.push_back(160);
    for (int b = 0; b < BEATS; b++) drive_beat(32'h0505_0505);
    @(negedge clk);                       // RESOLVE
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid",    int'(out_valid), 1);
      chk("hold_sum",      int'(out_sum),   160);
      chk("hold_in_ready", int'(in_ready),  0);
    end
    step();
    out_ready = 1'b1;
    step();                               // handshake edge
    @(negedge clk);
    chk("after_hold_in_ready", int'(in_ready), 1);
    chk("after_hold_busy",     int'(busy),     0);
    step();

    // 4: clr after 3 beats of 7s; beat presented with clr not taken
    exp_q.push_back(32);
    for (int b = 0; b < 3; b++) drive_beat(32'h0707_0707);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h0707_0707;
    @(negedge clk);
    chk("clr_in_ready", int'(in_ready), 0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_busy",     int'(busy),         0);
    chk("clr_beat_cnt", int'(dut.beat_cnt), 0);
    step();
    for (int b = 0; b < BEATS; b++) drive_beat(32'h0101_0101);
    repeat (4) step();

    // 5: async rst mid-ACC, then a fresh sum of 2s -> 64
    for (int b = 0; b < 3; b++) drive_beat(32'h0202_0202);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_sum",   int'(out_sum),   0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy",      int'(busy),      0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", int'(in_ready), 1);
    step();
    exp_q.push_back(64);
    for (int b = 0; b < BEATS; b++) drive_beat(32'h0202_0202);
    repeat (4) step();

    // 6: back-to-back sums, spacing BEATS+2
    pop_cyc.delete();
    exp_q.push_back(32);
    exp_q.push_back(96);
    for (int b = 0; b < BEATS; b++) drive_beat(32'h0101_0101);
    for (int b = 0; b < BEATS; b++) drive_beat(32'h0303_0303);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk("b2b_results", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2)
      chk("b2b_spacing", pop_cyc[1] - pop_cyc[0], BEATS + 2);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
